// File: rtl/sdram_uart_pkg.sv
// Shared types and widths for the UART <-> SDRAM frame sequencer.
package sdram_uart_pkg;
  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 16;
  localparam int RD_NUM_W = 10;

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT_RD,
    S_POP,
    S_XFER
  } seq_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_CAPTURE,
    T_TX_HI,
    T_GAP_HI,
    T_TX_LO,
    T_GAP_LO
  } tx_state_t;
endpackage

// File: rtl/sdram_uart_tx_unpack.sv
// Captures one read-FIFO word and hands its two bytes (high first) to the UART TX,
// leaving one gap cycle after each tx_req so a late-rising tx_busy is never missed.
module sdram_uart_tx_unpack
  import sdram_uart_pkg::*;
(
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              done,
  input  logic              tx_busy,
  output logic              tx_req,
  output logic [BYTE_W-1:0] tx_data
);

  tx_state_t         state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= T_IDLE;
      shift_q   <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    tx_data_d = tx_data_q;
    tx_req    = 1'b0;
    done      = 1'b0;
    case (state_q)
      T_IDLE:    if (start) state_d = T_CAPTURE;
      T_CAPTURE: begin
        shift_d = word;
        state_d = T_TX_HI;
      end
      T_TX_HI: if (!tx_busy) begin
        tx_req    = 1'b1;
        tx_data_d = shift_q[WORD_W-1:BYTE_W];
        state_d   = T_GAP_HI;
      end
      T_GAP_HI:  state_d = T_TX_LO;
      T_TX_LO: if (!tx_busy) begin
        tx_req    = 1'b1;
        tx_data_d = shift_q[BYTE_W-1:0];
        state_d   = T_GAP_LO;
      end
      T_GAP_LO: begin
        done    = 1'b1;
        state_d = T_IDLE;
      end
      default:   state_d = T_IDLE;
    endcase
  end

  // tx_data moves in the same cycle as tx_req and holds until the next strobe
  assign tx_data = tx_data_d;

endmodule

// File: rtl/sdram_uart_seq.sv
// Frame sequencer: packs UART bytes into SDRAM write-FIFO words, then reads the frame
// back and serialises it to UART TX. Define SDRAM_UART_SEQ_DROP_CNT_EN for drop_cnt.
module sdram_uart_seq
  import sdram_uart_pkg::*;
#(
  parameter int FRAME_WORDS = 10
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_req,
  input  logic                tx_busy,
  output logic                wr_fifo_wr_req,
  output logic [WORD_W-1:0]   wr_fifo_wr_data,
  output logic                rd_fifo_rd_req,
  input  logic [WORD_W-1:0]   rd_fifo_rd_data,
  input  logic [RD_NUM_W-1:0] rd_fifo_num,
  output logic                read_valid,
  output logic                frame_done
`ifdef SDRAM_UART_SEQ_DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  localparam logic [RD_NUM_W-1:0] LAST_WORD = RD_NUM_W'(FRAME_WORDS - 1);
  localparam logic [RD_NUM_W-1:0] FRAME_LVL = RD_NUM_W'(FRAME_WORDS);

  seq_state_t          state_q, state_d;
  logic [RD_NUM_W-1:0] word_cnt_q, word_cnt_d;
  logic                parity_q, parity_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                wr_req_q, wr_req_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                unpack_done;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      word_cnt_q <= '0;
      parity_q   <= 1'b0;
      hi_q       <= '0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      parity_q   <= parity_d;
      hi_q       <= hi_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    parity_d   = parity_q;
    hi_d       = hi_q;
    wr_req_d   = 1'b0;
    wr_data_d  = wr_data_q;
    frame_done = 1'b0;
    case (state_q)
      S_FILL: if (rx_valid) begin
        if (!parity_q) begin
          hi_d     = rx_data;
          parity_d = 1'b1;
        end else begin
          parity_d  = 1'b0;
          wr_req_d  = 1'b1;
          wr_data_d = {hi_q, rx_data};
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = S_WAIT_RD;
          end else begin
            word_cnt_d = word_cnt_q + 10'd1;
          end
        end
      end
      S_WAIT_RD: if (rd_fifo_num >= FRAME_LVL) state_d = S_POP;
      S_POP:     state_d = S_XFER;
      // word_cnt now counts words sent back out
      S_XFER: if (unpack_done) begin
        if (word_cnt_q == LAST_WORD) begin
          word_cnt_d = '0;
          frame_done = 1'b1;
          parity_d   = 1'b0;
          state_d    = S_FILL;
        end else begin
          word_cnt_d = word_cnt_q + 10'd1;
          state_d    = S_POP;
        end
      end
      default:   state_d = S_FILL;
    endcase
  end

  assign wr_fifo_wr_req  = wr_req_q;
  assign wr_fifo_wr_data = wr_data_q;
  assign rd_fifo_rd_req  = (state_q == S_POP);
  assign read_valid      = (state_q != S_FILL);

  sdram_uart_tx_unpack u_unpack (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .start   (rd_fifo_rd_req),
    .word    (rd_fifo_rd_data),
    .done    (unpack_done),
    .tx_busy (tx_busy),
    .tx_req  (tx_req),
    .tx_data (tx_data)
  );

`ifdef SDRAM_UART_SEQ_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (rx_valid && (state_q != S_FILL) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_sdram_uart_seq.sv
// Directed bench for sdram_uart_seq with a queue model of the SDRAM FIFOs and a UART busy model.
module tb_sdram_uart_seq;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_busy;
  logic        wr_fifo_wr_req;
  logic [15:0] wr_fifo_wr_data;
  logic        rd_fifo_rd_req;
  logic [15:0] rd_fifo_rd_data;
  logic [9:0]  rd_fifo_num = 10'd0;
  logic        read_valid;
  logic        frame_done;
`ifdef SDRAM_UART_SEQ_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          busy_en = 1'b0;
  int          busy_cnt = 0;
  logic [15:0] fq[$];

  sdram_uart_seq #(.FRAME_WORDS(10)) dut (
    .clk_50m         (clk_50m),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .tx_data         (tx_data),
    .tx_req          (tx_req),
    .tx_busy         (tx_busy),
    .wr_fifo_wr_req  (wr_fifo_wr_req),
    .wr_fifo_wr_data (wr_fifo_wr_data),
    .rd_fifo_rd_req  (rd_fifo_rd_req),
    .rd_fifo_rd_data (rd_fifo_rd_data),
    .rd_fifo_num     (rd_fifo_num),
    .read_valid      (read_valid),
    .frame_done      (frame_done)
`ifdef SDRAM_UART_SEQ_DROP_CNT_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  // UART TX stays busy for 50 cycles after each accepted start strobe
  always @(posedge clk_50m) begin
    if (tx_req) busy_cnt <= 50;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_en && (busy_cnt != 0);

  // SDRAM write->read path as one queue; read data appears the cycle after rd_req
  always @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      rd_fifo_rd_data <= 16'h0000;
    end else begin
      if (wr_fifo_wr_req) fq.push_back(wr_fifo_wr_data);
      if (rd_fifo_rd_req && (fq.size() > 0)) rd_fifo_rd_data <= fq.pop_front();
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_50m);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_50m);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [28:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    outs = {wr_fifo_wr_req, wr_fifo_wr_data, rd_fifo_rd_req, read_valid, tx_req, tx_data, frame_done};
    total++;
    if (outs !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk_50m);
    total++;
    if ({wr_fifo_wr_req, read_valid, rd_fifo_rd_req} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release: got %b want 000", {wr_fifo_wr_req, read_valid, rd_fifo_rd_req});
    end
  endtask

  task automatic test_fill(input logic [7:0] base);
    logic [15:0] exp_w;
    rd_fifo_num = 10'd0;
    for (int i = 0; i < 20; i++) begin
      send_byte(base + 8'(i));
      total++;
      if (i % 2 == 1) begin
        exp_w = {8'(base + 8'(i - 1)), 8'(base + 8'(i))};
        if ({wr_fifo_wr_req, wr_fifo_wr_data} !== {1'b1, exp_w}) begin
          bad++;
          $display("FAIL fill_write[%0d]: got req=%b data=%h want req=1 data=%h",
                   i, wr_fifo_wr_req, wr_fifo_wr_data, exp_w);
        end
      end else if (wr_fifo_wr_req !== 1'b0) begin
        bad++;
        $display("FAIL fill_even_nowrite[%0d]: got req=%b want 0", i, wr_fifo_wr_req);
      end
      if (i == 18) begin
        total++;
        if (read_valid !== 1'b0) begin
          bad++;
          $display("FAIL fill_read_valid_low: got %b want 0", read_valid);
        end
      end
    end
    total++;
    if (read_valid !== 1'b1) begin
      bad++;
      $display("FAIL fill_read_valid_high: got %b want 1", read_valid);
    end
  endtask

  task automatic test_wait_rd();
    rd_fifo_num = 10'd9;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_50m);
      total++;
      if (rd_fifo_rd_req !== 1'b0) begin
        bad++;
        $display("FAIL wait_rd_below_level[%0d]: got %b want 0", c, rd_fifo_rd_req);
      end
    end
    rd_fifo_num = 10'd10;
    @(negedge clk_50m);
    total++;
    if (rd_fifo_rd_req !== 1'b1) begin
      bad++;
      $display("FAIL wait_rd_first_pop: got %b want 1", rd_fifo_rd_req);
    end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hA0 + 8'(i));
      total++;
      if ({wr_fifo_wr_req, read_valid} !== 2'b01) begin
        bad++;
        $display("FAIL drop_nowrite[%0d]: got req=%b rv=%b want req=0 rv=1", i, wr_fifo_wr_req, read_valid);
      end
    end
`ifdef SDRAM_UART_SEQ_DROP_CNT_EN
    total++;
    if (drop_cnt !== 8'd3) begin
      bad++;
      $display("FAIL drop_cnt: got %0d want 3", drop_cnt);
    end
`endif
  endtask

  task automatic test_readback(input logic [7:0] base, input bit slow, input bit wait_req);
    bit          got;
    int          last;
    int          exp_gap;
    logic [7:0]  eb;
    busy_en     = slow;
    rd_fifo_num = 10'd10;
    last        = 0;
    if (wait_req) begin
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk_50m);
        if (rd_fifo_rd_req) begin
          got = 1'b1;
          break;
        end
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL readback_pop_timeout: got none want rd_fifo_rd_req");
      end
    end
    for (int i = 0; i < 20; i++) begin
      eb  = base + 8'(i);
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk_50m);
        if (tx_req) begin
          got = 1'b1;
          break;
        end
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL tx_timeout[%0d]: got no tx_req want byte %h", i, eb);
        continue;
      end
      total++;
      if ({tx_data, tx_busy} !== {eb, 1'b0}) begin
        bad++;
        $display("FAIL tx_byte[%0d]: got %h busy=%b want %h busy=0", i, tx_data, tx_busy, eb);
      end
      if (i > 0) begin
        exp_gap = slow ? 51 : ((i % 2 == 1) ? 2 : 4);
        total++;
        if (cyc - last !== exp_gap) begin
          bad++;
          $display("FAIL tx_spacing[%0d]: got %0d want %0d", i, cyc - last, exp_gap);
        end
      end
      last = cyc;
    end
    @(negedge clk_50m);
    total++;
    if (frame_done !== 1'b1) begin
      bad++;
      $display("FAIL frame_done_pulse: got %b want 1", frame_done);
    end
    @(negedge clk_50m);
    total++;
    if ({frame_done, read_valid} !== 2'b00) begin
      bad++;
      $display("FAIL frame_end_idle: got fd=%b rv=%b want 0 0", frame_done, read_valid);
    end
    busy_en     = 1'b0;
    rd_fifo_num = 10'd0;
  endtask

  task automatic test_mid_reset();
    logic [28:0] outs;
    rd_fifo_num = 10'd0;
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    total++;
    if (wr_fifo_wr_data !== 16'h5253) begin
      bad++;
      $display("FAIL mid_reset_pre_write: got %h want 5253", wr_fifo_wr_data);
    end
    rst_n = 1'b0;
    @(negedge clk_50m);
    outs = {wr_fifo_wr_req, wr_fifo_wr_data, rd_fifo_rd_req, read_valid, tx_req, tx_data, frame_done};
    total++;
    if (outs !== 29'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk_50m);
  endtask

  initial begin
    test_reset();
    test_fill(8'h00);
    test_wait_rd();
    test_readback(8'h00, 1'b0, 1'b0);
    test_fill(8'h20);
    test_drop();
    test_readback(8'h20, 1'b1, 1'b1);
    test_fill(8'h40);
    test_readback(8'h40, 1'b0, 1'b1);
    test_mid_reset();
    test_fill(8'h60);
    test_readback(8'h60, 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
